// File: rtl/scan_chain_pkg.sv
// rtl/scan_chain_pkg.sv - shared types and sizing helpers for the scan chain loader
//
// Purpose : FSM state encoding and width/count helpers used by
//           scan_chain_loader and scan_word_serdes.
// Ports   : none (package)
package scan_chain_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SHIFT,
    DRAIN,
    DONE
  } state_t;

  // Width of a counter that must reach chain_len inclusive.
  function automatic int cnt_width(input int chain_len);
    return $clog2(chain_len + 1);
  endfunction

  // Number of config words that fill the chain.
  function automatic int word_count(input int chain_len, input int word_w);
    return chain_len / word_w;
  endfunction

  // Width of the per-word bit index; never zero so a 1-bit word still builds.
  function automatic int sub_width(input int word_w);
    return (word_w > 1) ? $clog2(word_w) : 1;
  endfunction

endpackage

// File: rtl/scan_word_serdes.sv
// rtl/scan_word_serdes.sv - one-word serialiser/deserialiser between the FSM and the scan chain
//
// Purpose : holds the outgoing config word (shift_reg) and the incoming
//           readback word (rb_reg). Both move one bit per shift strobe.
// Ports   : clk, R        - clock, synchronous active-high reset
//           load          - latch load_data into shift_reg
//           load_data     - config word, bit 0 leaves first
//           shift         - advance both registers by one bit
//           so            - chain tail bit captured on shift
//           si            - current outgoing bit (shift_reg[0])
//           rb_next       - readback word as it will be after this shift
module scan_word_serdes #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              R,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic              shift,
  input  logic              so,
  output logic              si,
  output logic [WORD_W-1:0] rb_next
);

  logic [WORD_W-1:0] shift_reg;
  logic [WORD_W-1:0] rb_reg;

  assign si = shift_reg[0];

  // Tail bits enter at the MSB and walk down, so after WORD_W shifts the
  // first-received bit lands in bit 0. Exposed combinationally so the top
  // can capture the completed word on the same edge as its last bit.
  always_comb begin
    rb_next = rb_reg >> 1;
    rb_next[WORD_W-1] = so;
  end

  always_ff @(posedge clk) begin
    if (R) begin
      shift_reg <= '0;
      rb_reg    <= '0;
    end else begin
      if (load) begin
        shift_reg <= load_data;
      end else if (shift) begin
        shift_reg <= shift_reg >> 1;
      end
      if (shift) begin
        rb_reg <= rb_next;
      end
    end
  end

endmodule

// File: rtl/scan_chain_loader.sv
// rtl/scan_chain_loader.sv - loads config words into an scff scan chain and returns the old contents
//
// Purpose : accepts config words on a valid/ready stream, shifts them LSB
//           first into the chain head, and reassembles the chain tail bits
//           into readback words on a second valid/ready stream.
// Ports   : clk, R                  - clock, synchronous active-high reset
//           start                   - begin a pass (IDLE only)
//           in_data/in_valid/in_ready    - config word stream
//           scan_si/scan_en/scan_so - chain head data, shift strobe, tail data
//           out_data/out_valid/out_ready - readback word stream
//           busy, done, bit_cnt     - pass status
module scan_chain_loader
  import scan_chain_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = cnt_width(CHAIN_LEN)
) (
  input  logic              clk,
  input  logic              R,
  input  logic              start,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              scan_si,
  output logic              scan_en,
  input  logic              scan_so,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_cnt
);

  localparam int N_WORDS = word_count(CHAIN_LEN, WORD_W);
  localparam int SUB_W   = sub_width(WORD_W);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N_WORDS * WORD_W - 1);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(WORD_W - 1);

  state_t           state;
  logic [SUB_W-1:0] sub_cnt;
  logic             hold_free;
  logic             shift_now;
  logic             load_now;
  logic             ser_si;
  logic [WORD_W-1:0] rb_next;

  // The chain may only advance while the readback holder can take the word
  // being assembled. Reset gates the strobe so the chain does not move on
  // the edge that abandons a pass.
  assign hold_free = !out_valid || out_ready;
  assign shift_now = (state == SHIFT) && hold_free && !R;
  assign load_now  = (state == FETCH) && in_valid && in_ready;

  assign scan_en = shift_now;
  assign scan_si = (state == SHIFT) ? ser_si : 1'b0;

  scan_word_serdes #(
    .WORD_W(WORD_W)
  ) u_serdes (
    .clk      (clk),
    .R        (R),
    .load     (load_now),
    .load_data(in_data),
    .shift    (shift_now),
    .so       (scan_so),
    .si       (ser_si),
    .rb_next  (rb_next)
  );

  always_ff @(posedge clk) begin
    if (R) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bit_cnt   <= '0;
      sub_cnt   <= '0;
    end else begin
      done <= 1'b0;
      // A word completing below on the same edge overrides this release.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state    <= FETCH;
            busy     <= 1'b1;
            bit_cnt  <= '0;
            in_ready <= 1'b1;
          end
        end

        FETCH: begin
          if (load_now) begin
            in_ready <= 1'b0;
            sub_cnt  <= '0;
            state    <= SHIFT;
          end
        end

        SHIFT: begin
          if (shift_now) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
            sub_cnt <= sub_cnt + SUB_W'(1);
            if (sub_cnt == SUB_LAST) begin
              out_data  <= rb_next;
              out_valid <= 1'b1;
              if (bit_cnt == LAST_BIT) begin
                state <= DRAIN;
              end else begin
                state    <= FETCH;
                in_ready <= 1'b1;
              end
            end
          end
        end

        DRAIN: begin
          if (!out_valid) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_chain_loader.sv
// tb/tb_scan_chain_loader.sv - directed self-checking bench for scan_chain_loader
module tb_scan_chain_loader;

  localparam int CL = 16;
  localparam int WW = 8;

  logic          clk = 1'b0;
  logic          R = 1'b1;
  logic          start = 1'b0;
  logic [WW-1:0] in_data;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          scan_si;
  logic          scan_en;
  logic          scan_so;
  logic [WW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          busy;
  logic          done;
  logic [4:0]    bit_cnt;

  int checks = 0;
  int failures = 0;

  // Behavioural scff chain: head is bit 0, tail is bit 15.
  logic [CL-1:0] chain;
  logic          preload = 1'b0;
  assign scan_so = chain[CL-1];

  bit            si_log[$];
  logic [WW-1:0] rd_log[$];
  int en_cnt = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int hs_base = 0;
  logic [WW-1:0] w0 = '0;
  logic [WW-1:0] w1 = '0;

  assign in_data = (hs_cnt == hs_base) ? w0 : w1;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preload) chain <= {CL{1'b1}};
    else if (scan_en) chain <= {chain[CL-2:0], scan_si};
    if (scan_en) begin
      si_log.push_back(scan_si);
      en_cnt <= en_cnt + 1;
    end
    if (out_valid && out_ready) rd_log.push_back(out_data);
    if (in_valid && in_ready) hs_cnt <= hs_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  scan_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
    .clk(clk), .R(R), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .scan_si(scan_si), .scan_en(scan_en), .scan_so(scan_so),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .bit_cnt(bit_cnt)
  );

  task automatic get_si(input int base, output logic [15:0] v);
    for (int i = 0; i < 16; i++) v[i] = (base + i < si_log.size()) ? si_log[base + i] : 1'bx;
  endtask

  task automatic wait_done(input int limit, output int n, output bit to);
    n = 1;
    to = 1'b1;
    for (int i = 0; i < limit; i++) begin
      if (done === 1'b1) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_preload();
    @(negedge clk) preload = 1'b1;
    @(negedge clk) preload = 1'b0;
  endtask

  task automatic run_pass(input logic [7:0] a, input logic [7:0] b, output int n, output bit to);
    @(negedge clk);
    w0 = a; w1 = b; hs_base = hs_cnt; start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done(200, n, to);
    @(negedge clk);
  endtask

  task automatic test_reset();
    R = 1'b1; preload = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (scan_en !== 1'b0) begin failures++; $display("FAIL reset_scan_en got=%b exp=0", scan_en); end
    checks++; if (scan_si !== 1'b0) begin failures++; $display("FAIL reset_scan_si got=%b exp=0", scan_si); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (bit_cnt !== 5'd0) begin failures++; $display("FAIL reset_bit_cnt got=%0d exp=0", bit_cnt); end
    R = 1'b0; preload = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int sb, rb, eb, db, n;
    bit to;
    logic [15:0] v;
    sb = si_log.size(); rb = rd_log.size(); eb = en_cnt; db = done_cnt;
    in_valid = 1'b1; out_ready = 1'b1;
    run_pass(8'hA5, 8'h3C, n, to);
    checks++; if (to) begin failures++; $display("FAIL basic_timeout got=no_done exp=done"); end
    checks++; if (n != 21) begin failures++; $display("FAIL basic_latency got=%0d exp=21", n); end
    get_si(sb, v);
    checks++; if (v !== 16'h3CA5) begin failures++; $display("FAIL basic_si_seq got=%h exp=3ca5", v); end
    checks++; if (rd_log.size() != rb + 2) begin failures++; $display("FAIL basic_rd_count got=%0d exp=2", rd_log.size() - rb); end
    else begin
      checks++; if (rd_log[rb] !== 8'hFF) begin failures++; $display("FAIL basic_rd0 got=%h exp=ff", rd_log[rb]); end
      checks++; if (rd_log[rb+1] !== 8'hFF) begin failures++; $display("FAIL basic_rd1 got=%h exp=ff", rd_log[rb+1]); end
    end
    checks++; if (en_cnt - eb != 16) begin failures++; $display("FAIL basic_en_pulses got=%0d exp=16", en_cnt - eb); end
    checks++; if (done_cnt - db != 1) begin failures++; $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt - db); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
    checks++; if (bit_cnt !== 5'd16) begin failures++; $display("FAIL basic_bit_cnt_hold got=%0d exp=16", bit_cnt); end
  endtask

  task automatic test_roundtrip();
    int rb, n;
    bit to;
    rb = rd_log.size();
    run_pass(8'h00, 8'h00, n, to);
    checks++; if (to) begin failures++; $display("FAIL rt_timeout got=no_done exp=done"); end
    checks++; if (rd_log.size() != rb + 2) begin failures++; $display("FAIL rt_rd_count got=%0d exp=2", rd_log.size() - rb); end
    else begin
      checks++; if (rd_log[rb] !== 8'hA5) begin failures++; $display("FAIL rt_rd0 got=%h exp=a5", rd_log[rb]); end
      checks++; if (rd_log[rb+1] !== 8'h3C) begin failures++; $display("FAIL rt_rd1 got=%h exp=3c", rd_log[rb+1]); end
    end
    checks++; if (chain !== 16'h0000) begin failures++; $display("FAIL rt_chain got=%h exp=0000", chain); end
  endtask

  task automatic test_reset_mid_shift();
    int sb, rb, eb, n;
    bit to, reached;
    logic [15:0] v;
    do_preload();
    eb = en_cnt;
    @(negedge clk);
    w0 = 8'hA5; w1 = 8'h00; hs_base = hs_cnt; start = 1'b1;
    @(negedge clk) start = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (en_cnt - eb == 3) begin reached = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!reached) begin failures++; $display("FAIL rmid_reach got=%0d exp=3 shifts", en_cnt - eb); end
    R = 1'b1;
    @(negedge clk);
    R = 1'b0;
    checks++; if (en_cnt - eb != 3) begin failures++; $display("FAIL rmid_no_extra_shift got=%0d exp=3", en_cnt - eb); end
    checks++; if ({in_ready, scan_en, scan_si, out_valid, busy, done} !== 6'b0) begin
      failures++; $display("FAIL rmid_ctrl got=%b exp=000000", {in_ready, scan_en, scan_si, out_valid, busy, done}); end
    checks++; if (bit_cnt !== 5'd0) begin failures++; $display("FAIL rmid_bit_cnt got=%0d exp=0", bit_cnt); end
    checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL rmid_out_data got=%h exp=00", out_data); end
    sb = si_log.size(); rb = rd_log.size(); eb = en_cnt;
    run_pass(8'h3C, 8'h5A, n, to);
    checks++; if (to) begin failures++; $display("FAIL rmid_timeout got=no_done exp=done"); end
    checks++; if (n != 21) begin failures++; $display("FAIL rmid_latency got=%0d exp=21", n); end
    get_si(sb, v);
    checks++; if (v !== 16'h5A3C) begin failures++; $display("FAIL rmid_si_seq got=%h exp=5a3c", v); end
    checks++; if (en_cnt - eb != 16) begin failures++; $display("FAIL rmid_en_pulses got=%0d exp=16", en_cnt - eb); end
    // Chain held FFFF advanced by bits 1,0,1 before the abort.
    checks++; if (rd_log.size() != rb + 2) begin failures++; $display("FAIL rmid_rd_count got=%0d exp=2", rd_log.size() - rb); end
    else begin
      checks++; if (rd_log[rb] !== 8'hFF) begin failures++; $display("FAIL rmid_rd0 got=%h exp=ff", rd_log[rb]); end
      checks++; if (rd_log[rb+1] !== 8'hBF) begin failures++; $display("FAIL rmid_rd1 got=%h exp=bf", rd_log[rb+1]); end
    end
  endtask

  task automatic test_starvation();
    int sb, rb, eb, n;
    bit to, reached, en_seen, cnt_moved;
    logic [15:0] v;
    sb = si_log.size(); rb = rd_log.size(); eb = en_cnt;
    @(negedge clk);
    w0 = 8'h5A; w1 = 8'hC3; hs_base = hs_cnt; in_valid = 1'b1; start = 1'b1;
    @(negedge clk) start = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (in_ready === 1'b1 && bit_cnt == 5'd8) begin reached = 1'b1; break; end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (!reached) begin failures++; $display("FAIL starve_reach got=%0d exp=8", bit_cnt); end
    en_seen = 1'b0; cnt_moved = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (scan_en !== 1'b0) en_seen = 1'b1;
      if (bit_cnt !== 5'd8) cnt_moved = 1'b1;
    end
    checks++; if (en_seen) begin failures++; $display("FAIL starve_scan_en got=1 exp=0"); end
    checks++; if (cnt_moved) begin failures++; $display("FAIL starve_bit_cnt got=%0d exp=8", bit_cnt); end
    in_valid = 1'b1;
    wait_done(200, n, to);
    @(negedge clk);
    checks++; if (to) begin failures++; $display("FAIL starve_timeout got=no_done exp=done"); end
    get_si(sb, v);
    checks++; if (v !== 16'hC35A) begin failures++; $display("FAIL starve_si_seq got=%h exp=c35a", v); end
    checks++; if (en_cnt - eb != 16) begin failures++; $display("FAIL starve_en_pulses got=%0d exp=16", en_cnt - eb); end
    checks++; if (rd_log.size() != rb + 2) begin failures++; $display("FAIL starve_rd_count got=%0d exp=2", rd_log.size() - rb); end
    else begin
      checks++; if (rd_log[rb] !== 8'h3C) begin failures++; $display("FAIL starve_rd0 got=%h exp=3c", rd_log[rb]); end
      checks++; if (rd_log[rb+1] !== 8'h5A) begin failures++; $display("FAIL starve_rd1 got=%h exp=5a", rd_log[rb+1]); end
    end
  endtask

  task automatic test_backpressure();
    int sb, rb, eb, e1, n;
    bit to, reached, stable;
    logic [15:0] v;
    do_preload();
    sb = si_log.size(); rb = rd_log.size(); eb = en_cnt;
    @(negedge clk);
    w0 = 8'h11; w1 = 8'h22; hs_base = hs_cnt; in_valid = 1'b1; out_ready = 1'b1; start = 1'b1;
    @(negedge clk) start = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid === 1'b1) begin reached = 1'b1; break; end
      @(negedge clk);
    end
    out_ready = 1'b0;
    checks++; if (!reached) begin failures++; $display("FAIL bp_reach got=no_word exp=word"); end
    e1 = en_cnt; stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (out_data !== 8'hFF || out_valid !== 1'b1) stable = 1'b0;
    end
    checks++; if (en_cnt - e1 > WW) begin failures++; $display("FAIL bp_extra_shifts got=%0d exp<=8", en_cnt - e1); end
    checks++; if (scan_en !== 1'b0) begin failures++; $display("FAIL bp_scan_en got=%b exp=0", scan_en); end
    checks++; if (!stable) begin failures++; $display("FAIL bp_hold got=%h/%b exp=ff/1", out_data, out_valid); end
    out_ready = 1'b1;
    wait_done(200, n, to);
    @(negedge clk);
    checks++; if (to) begin failures++; $display("FAIL bp_timeout got=no_done exp=done"); end
    checks++; if (en_cnt - eb != 16) begin failures++; $display("FAIL bp_en_pulses got=%0d exp=16", en_cnt - eb); end
    get_si(sb, v);
    checks++; if (v !== 16'h2211) begin failures++; $display("FAIL bp_si_seq got=%h exp=2211", v); end
    checks++; if (rd_log.size() != rb + 2) begin failures++; $display("FAIL bp_rd_count got=%0d exp=2", rd_log.size() - rb); end
    else begin
      checks++; if (rd_log[rb] !== 8'hFF) begin failures++; $display("FAIL bp_rd0 got=%h exp=ff", rd_log[rb]); end
      checks++; if (rd_log[rb+1] !== 8'hFF) begin failures++; $display("FAIL bp_rd1 got=%h exp=ff", rd_log[rb+1]); end
    end
  endtask

  task automatic test_start_during_busy();
    int rb, eb, db;
    bit seen;
    rb = rd_log.size(); eb = en_cnt; db = done_cnt;
    @(negedge clk);
    w0 = 8'h77; w1 = 8'h88; hs_base = hs_cnt; start = 1'b1;
    @(negedge clk) start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin seen = 1'b1; break; end
      start = (i == 3 || i == 10 || i == 19);
    end
    start = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (!seen) begin failures++; $display("FAIL sb_timeout got=no_done exp=done"); end
    checks++; if (done_cnt - db != 1) begin failures++; $display("FAIL sb_done_pulses got=%0d exp=1", done_cnt - db); end
    checks++; if (en_cnt - eb != 16) begin failures++; $display("FAIL sb_en_pulses got=%0d exp=16", en_cnt - eb); end
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL sb_idle got=busy%b/rdy%b exp=0/0", busy, in_ready); end
    checks++; if (rd_log.size() != rb + 2) begin failures++; $display("FAIL sb_rd_count got=%0d exp=2", rd_log.size() - rb); end
    else begin
      checks++; if (rd_log[rb] !== 8'h11) begin failures++; $display("FAIL sb_rd0 got=%h exp=11", rd_log[rb]); end
      checks++; if (rd_log[rb+1] !== 8'h22) begin failures++; $display("FAIL sb_rd1 got=%h exp=22", rd_log[rb+1]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_roundtrip();
    test_reset_mid_shift();
    test_starvation();
    test_backpressure();
    test_start_during_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
